mem_port_ir: RTL and testbench

// - Unified-memory port and instruction/data capture stage. It sits between the multi-cycle control FSM and datapath on one side, and the single shared instruction/data memory on the other.
// - Turns the FSM strobes (IRWrite, MemWrite, a load-read strobe, AddrSrc) into a req/ack bus transaction against a wait-stated memory.
// - Holds the instruction register (IR), OldPC and the Data register. It stalls the FSM via busy until each access completes.

---
 rtl/mem_port_ir_pkg.sv | 42 ++++
 rtl/mem_port_ir_bus_timeout_ctr.sv | 34 +++
 rtl/mem_port_ir.sv | 172 +++++++++++++++++
 tb/tb_mem_port_ir.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mem_port_ir_pkg.sv
// Shared definitions for the unified-memory port: widths, reset IR value,
// opcode constants, port state/command encodings and command decode.
package mem_port_ir_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0 -- the canonical NOP, also the IR value after reset
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_IR  = NOP_INSTR;

    // Opcodes the control FSM decodes from instr[6:0]
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic {
        PS_IDLE = 1'b0,
        PS_BUS  = 1'b1
    } port_state_e;

    typedef enum logic [1:0] {
        CMD_FETCH = 2'd0,
        CMD_STORE = 2'd1,
        CMD_LOAD  = 2'd2
    } port_cmd_e;

    // Priority among simultaneous strobes: fetch over store over load
    function automatic port_cmd_e decode_cmd(input logic iw, input logic mw);
        if (iw) begin
            return CMD_FETCH;
        end else if (mw) begin
            return CMD_STORE;
        end else begin
            return CMD_LOAD;
        end
    endfunction

endpackage

// File: rtl/mem_port_ir_bus_timeout_ctr.sv
// Saturating wait counter for a bus transaction; expired once it has
// counted TIMEOUT-1 cycles past the clear.
module mem_port_ir_bus_timeout_ctr #(
    parameter int TIMEOUT = 16
)(
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] r_count;

    // Clear on transaction start, count while enabled, hold at LAST
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != LAST)) begin
            r_count <= r_count + ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/mem_port_ir.sv
// Unified-memory port and IR/data capture stage: turns FSM fetch/load/store
// strobes into one req/ack bus transaction and stalls the FSM until done.
module mem_port_ir
    import mem_port_ir_pkg::*;
#(
    parameter int              XLEN     = mem_port_ir_pkg::XLEN,
    parameter int              TIMEOUT  = 16,
    parameter logic [XLEN-1:0] RESET_IR = mem_port_ir_pkg::RESET_IR
)(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] wdata,
    input  logic            addr_src,
    input  logic            ir_write,
    input  logic            mem_write,
    input  logic            mem_read,
    output logic            busy,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] old_pc,
    output logic [XLEN-1:0] data_reg,
    output logic            bus_err,
    output logic            misalign_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack
);

    port_state_e     r_state, w_state_nxt;
    port_cmd_e       r_cmd, w_cmd;
    logic [XLEN-1:0] w_addr;
    logic            w_cmd_valid, w_aligned, w_accept, w_misalign;
    logic            w_ack_hit, w_expired, w_timeout;
    logic            r_mem_req, r_mem_we;
    logic [XLEN-1:0] r_mem_addr, r_mem_wdata, r_pc_lat;
    logic [XLEN-1:0] r_instr, r_old_pc, r_data;
    logic            r_bus_err, r_misalign_err;

    assign w_addr      = addr_src ? alu_out : pc;
    assign w_aligned   = (w_addr[1:0] == 2'b00);
    assign w_cmd_valid = ir_write | mem_write | mem_read;
    assign w_cmd       = decode_cmd(ir_write, mem_write);
    assign w_accept    = (r_state == PS_IDLE) & w_cmd_valid & w_aligned;
    assign w_misalign  = (r_state == PS_IDLE) & w_cmd_valid & ~w_aligned;
    // A late ack while idle is simply not qualified by the BUS state
    assign w_ack_hit   = (r_state == PS_BUS) & mem_ack;
    // Ack on the last allowed cycle still completes the access
    assign w_timeout   = (r_state == PS_BUS) & ~mem_ack & w_expired;

    mem_port_ir_bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_accept),
        .i_en      (r_state == PS_BUS),
        .o_expired (w_expired)
    );

    // Port state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= PS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and FSM stall; the accepting command cycle already stalls
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        case (r_state)
            PS_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = PS_BUS;
                    busy        = 1'b1;
                end else begin
                    w_state_nxt = PS_IDLE;
                    busy        = 1'b0;
                end
            end
            PS_BUS: begin
                busy = 1'b1;
                if (w_ack_hit || w_timeout) begin
                    w_state_nxt = PS_IDLE;
                end else begin
                    w_state_nxt = PS_BUS;
                end
            end
            default: begin
                w_state_nxt = PS_IDLE;
                busy        = 1'b0;
            end
        endcase
    end

    // Bus-side registers: sampled on accept, held through BUS, req dropped at end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_pc_lat    <= '0;
            r_cmd       <= CMD_FETCH;
        end else if (w_accept) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= (w_cmd == CMD_STORE);
            r_mem_addr  <= w_addr;
            r_mem_wdata <= wdata;
            r_pc_lat    <= pc;
            r_cmd       <= w_cmd;
        end else if (w_ack_hit || w_timeout) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
        end else begin
            r_mem_req   <= r_mem_req;
            r_mem_we    <= r_mem_we;
        end
    end

    // Capture returned data on the ack edge according to the latched command
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr  <= RESET_IR;
            r_old_pc <= '0;
            r_data   <= '0;
        end else if (w_ack_hit) begin
            case (r_cmd)
                CMD_FETCH: begin
                    r_instr  <= mem_rdata;
                    r_old_pc <= r_pc_lat;
                end
                CMD_LOAD: begin
                    r_data <= mem_rdata;
                end
                default: begin
                    r_instr <= r_instr;
                end
            endcase
        end else begin
            r_instr <= r_instr;
        end
    end

    // Single-cycle error pulses for timeout and refused misaligned access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bus_err      <= 1'b0;
            r_misalign_err <= 1'b0;
        end else begin
            r_bus_err      <= w_timeout;
            r_misalign_err <= w_misalign;
        end
    end

    assign instr        = r_instr;
    assign old_pc       = r_old_pc;
    assign data_reg     = r_data;
    assign bus_err      = r_bus_err;
    assign misalign_err = r_misalign_err;
    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_ir.sv
// Self-checking bench for mem_port_ir: directed scenarios plus randomized
// transactions against a transaction-level reference model.
module tb_mem_port_ir;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, alu_out, wdata, mem_rdata;
    logic        addr_src, ir_write, mem_write, mem_read, mem_ack;
    logic        busy, bus_err, misalign_err, mem_req, mem_we;
    logic [31:0] instr, old_pc, data_reg, mem_addr, mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural view kept by the bench
    logic [31:0] m_instr, m_old_pc, m_data;

    mem_port_ir #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .pc(pc), .alu_out(alu_out), .wdata(wdata),
        .addr_src(addr_src), .ir_write(ir_write), .mem_write(mem_write),
        .mem_read(mem_read), .busy(busy), .instr(instr), .old_pc(old_pc),
        .data_reg(data_reg), .bus_err(bus_err), .misalign_err(misalign_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_arch(input string tag);
        chk({tag, "_instr"}, instr, m_instr);
        chk({tag, "_oldpc"}, old_pc, m_old_pc);
        chk({tag, "_data"}, data_reg, m_data);
    endtask

    // One access issued at a negedge; waits<0 means the memory never acks.
    task automatic run_txn(input logic iw, input logic mw, input logic mr,
                           input logic asrc, input logic [31:0] pcv,
                           input logic [31:0] aluv, input logic [31:0] wd,
                           input int waits, input logic [31:0] rd);
        logic [31:0] addr;
        logic        is_store, is_load, done;
        int          busy_cycles, n;
        addr     = asrc ? aluv : pcv;
        is_store = !iw && mw;
        is_load  = !iw && !mw && mr;
        ir_write = iw; mem_write = mw; mem_read = mr; addr_src = asrc;
        pc = pcv; alu_out = aluv; wdata = wd; mem_ack = 1'b0;
        #1;
        if (addr[1:0] != 2'b00) begin
            chk("misal_busy", busy, 32'd0);
            @(negedge clk);
            ir_write = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
            chk("misal_pulse", misalign_err, 32'd1);
            chk("misal_noreq", mem_req, 32'd0);
            @(negedge clk);
            chk("misal_once", misalign_err, 32'd0);
            chk("misal_noreq2", mem_req, 32'd0);
            check_arch("misal");
            return;
        end
        chk("cmd_busy", busy, 32'd1);
        busy_cycles = 1;
        @(negedge clk);
        done = 1'b0;
        n = 0;
        while (!done && n < TO + 4) begin
            chk("req_held", mem_req, 32'd1);
            chk("addr_held", mem_addr, addr);
            chk("we_held", mem_we, {31'd0, is_store});
            chk("wdata_held", mem_wdata, wd);
            chk("no_err_bus", bus_err, 32'd0);
            if (busy) busy_cycles++;
            pc = $urandom; alu_out = $urandom; wdata = $urandom;
            if (waits >= 0 && n == waits) begin
                mem_ack = 1'b1;
                mem_rdata = rd;
            end
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            n++;
            if (waits >= 0 && n == waits + 1) done = 1'b1;
            if (waits < 0 && n == TO) done = 1'b1;
        end
        if (waits >= 0) begin
            if (iw) begin
                m_instr  = rd;
                m_old_pc = pcv;
            end else if (is_load) begin
                m_data = rd;
            end
        end
        ir_write = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
        #1;
        chk("done_busy", busy, 32'd0);
        chk("done_noreq", mem_req, 32'd0);
        chk("busy_len", busy_cycles, (waits >= 0) ? waits + 2 : TO + 1);
        chk("bus_err", bus_err, (waits >= 0) ? 32'd0 : 32'd1);
        check_arch("done");
        if (waits < 0) begin
            // A late ack in IDLE must not be captured
            @(negedge clk);
            chk("bus_err_once", bus_err, 32'd0);
            mem_ack = 1'b1;
            mem_rdata = ~m_instr;
            @(negedge clk);
            mem_ack = 1'b0;
            chk("late_ack_noreq", mem_req, 32'd0);
            check_arch("late_ack");
        end
    endtask

    initial begin
        logic [31:0] pcv, aluv, r;
        logic [2:0]  sel;
        logic        asrc;
        int          waits;
        reset = 1'b1;
        pc = 32'd0; alu_out = 32'd0; wdata = 32'd0; mem_rdata = 32'd0;
        addr_src = 1'b0; ir_write = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
        mem_ack = 1'b0;
        m_instr = 32'h0000_0013; m_old_pc = 32'd0; m_data = 32'd0;
        #12;
        chk("rst_req", mem_req, 32'd0);
        chk("rst_we", mem_we, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_errs", {bus_err, misalign_err}, 32'd0);
        check_arch("rst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed: zero-wait fetch, waited store, misaligned load, timeout
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 0, 32'h0050_0093);
        run_txn(1'b0, 1'b1, 1'b0, 1'b1, 32'h14, 32'h20, 32'hDEAD_BEEF, 3, 32'h0);
        run_txn(1'b0, 1'b0, 1'b1, 1'b1, 32'h14, 32'h22, 32'h0, 0, 32'h0);
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h18, 32'h0, 32'h0, -1, 32'h0);
        // Fetch and load together: fetch wins and the address is pc
        run_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h1C, 32'h40, 32'h0, 1, 32'h1234_5678);
        run_txn(1'b0, 1'b0, 1'b1, 1'b1, 32'h1C, 32'h44, 32'h0, 2, 32'hCAFE_F00D);

        // Randomized back-to-back traffic
        for (int i = 0; i < 40; i++) begin
            sel   = 3'($urandom_range(1, 7));
            asrc  = 1'($urandom_range(0, 1));
            r     = $urandom; pcv  = r & 32'hFFFF_FFFC;
            r     = $urandom; aluv = r & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) begin
                if (asrc) aluv = aluv | 32'($urandom_range(1, 3));
                else      pcv  = pcv  | 32'($urandom_range(1, 3));
            end
            waits = ($urandom_range(0, 11) == 0) ? -1 : $urandom_range(0, 5);
            run_txn(sel[0], sel[1], sel[2], asrc, pcv, aluv, $urandom, waits, $urandom);
        end

        // Reset in the second BUS cycle with an ack present: no capture
        ir_write = 1'b1; addr_src = 1'b0; pc = 32'h40;
        @(negedge clk);
        chk("rmid_req0", mem_req, 32'd1);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
        reset = 1'b1; ir_write = 1'b0;
        #1;
        chk("rmid_req", mem_req, 32'd0);
        m_instr = 32'h0000_0013; m_old_pc = 32'd0; m_data = 32'd0;
        check_arch("rmid");
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        chk("rmid_busy", busy, 32'd0);
        check_arch("rmid_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
